uart_cmd_assembler: RTL

Frames the byte stream from the configurable-baud UART receiver into 4-byte commands: opcode, data high byte, data low byte, checksum. Sits directly downstream of the receiver, consuming its `rdy`/`rx_data` and driving its `clr_rdy`. Presents a validated opcode plus 16-bit operand to the command processor with a sticky `cmd_rdy` handshake. Also provides inter-byte timeout resynchronisation and sticky error flags.

---
 rtl/uart_cmd_assembler_if.sv | 25 ++
 rtl/uart_cmd_assembler.sv | 120 ++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler_if.sv
// Byte-stream and command-handshake bundle between the UART receiver,
// the command assembler and the downstream command processor.
interface uart_cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_err;
  logic        cs_err;
  logic        to_err;
  logic        ovr_err;

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy, clr_err,
    output clr_rx_rdy, cmd, data, cmd_rdy, cs_err, to_err, ovr_err
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy, clr_err,
    input  clr_rx_rdy, cmd, data, cmd_rdy, cs_err, to_err, ovr_err
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Frames UART bytes into {opcode, data_hi, data_lo, checksum} commands with
// inter-byte timeout resync and sticky checksum/timeout/overrun flags.
module uart_cmd_assembler #(
  parameter int TIMEOUT_W = 20,
  parameter int TIMEOUT   = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_cmd_assembler_if.master  bus
);

  typedef enum logic [1:0] {WAIT_CMD, WAIT_DHI, WAIT_DLO, WAIT_CS} state_e;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [7:0]           dhi_q, dhi_d;
  logic [7:0]           dlo_q, dlo_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [15:0]          data_q, data_d;
  logic                 cmd_rdy_q, cmd_rdy_d;
  logic                 cs_err_q, cs_err_d;
  logic                 to_err_q, to_err_d;
  logic                 ovr_err_q, ovr_err_d;
  logic [7:0]           sum;

  // 8-bit wrap-around sum; a good frame totals 8'hFF.
  assign sum = op_q + dhi_q + dlo_q + bus.rx_data;

  assign bus.clr_rx_rdy = bus.rx_rdy;
  assign bus.cmd        = cmd_q;
  assign bus.data       = data_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.cs_err     = cs_err_q;
  assign bus.to_err     = to_err_q;
  assign bus.ovr_err    = ovr_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_CMD;
      op_q      <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      cnt_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      cs_err_q  <= 1'b0;
      to_err_q  <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dhi_q     <= dhi_d;
      dlo_q     <= dlo_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      cs_err_q  <= cs_err_d;
      to_err_q  <= to_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dhi_d     = dhi_q;
    dlo_d     = dlo_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    // Clears are applied first so a same-cycle set overrides them.
    cmd_rdy_d = cmd_rdy_q & ~bus.clr_cmd_rdy;
    cs_err_d  = cs_err_q  & ~bus.clr_err;
    to_err_d  = to_err_q  & ~bus.clr_err;
    ovr_err_d = ovr_err_q & ~bus.clr_err;

    if (state_q == WAIT_CMD) begin
      cnt_d = '0;
      if (bus.rx_rdy) begin
        op_d    = bus.rx_data;
        state_d = WAIT_DHI;
      end
    end else if (bus.rx_rdy) begin
      cnt_d = '0;
      case (state_q)
        WAIT_DHI: begin
          dhi_d   = bus.rx_data;
          state_d = WAIT_DLO;
        end
        WAIT_DLO: begin
          dlo_d   = bus.rx_data;
          state_d = WAIT_CS;
        end
        default: begin
          state_d = WAIT_CMD;
          if (sum == 8'hFF) begin
            cmd_d     = op_q;
            data_d    = {dhi_q, dlo_q};
            cmd_rdy_d = 1'b1;
            if (cmd_rdy_q) ovr_err_d = 1'b1;
          end else begin
            cs_err_d = 1'b1;
          end
        end
      endcase
    end else if (cnt_q == TO_LAST) begin
      state_d  = WAIT_CMD;
      to_err_d = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule
